if_fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the 16-bit PC and talks to instruction memory through a variable-latency req/ready handshake.
- Presents registered pc, pc+2, instruction and valid to IF/ID.
- Honours hazard-unit stalls and branch redirects from EX.

---
 rtl/if_fetch_stage.sv | 119 +++++++++++
 tb/tb_if_fetch_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
//   16-bit fetch PC, issues requests to instruction memory over a
//   variable-latency req/ready handshake, and presents a registered
//   {pc, pc+2, instruction, valid} to IF/ID. Honours hazard stalls and
//   single-cycle branch redirects from EX.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   stall           IF/ID cannot accept; presented outputs freeze
//   branch_taken    redirect pulse from EX (highest priority)
//   branch_target   redirect address, bit0 forced to 0
//   imem_req        fetch request, imem_addr stable while high
//   imem_addr       current fetch PC
//   imem_rdata      instruction word, qualified by imem_ready
//   imem_ready      response strobe for the current imem_addr
//   pc_out          PC of the presented instruction
//   pc_plus2_out    pc_out + 2 (mod 2^16)
//   instruction_out presented instruction word (NOP_INSTR on bubbles)
//   valid_out       1 = real instruction, 0 = bubble
//   fetch_count     instructions delivered to IF/ID, wraps
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2_out,
    output logic [15:0] instruction_out,
    output logic        valid_out,
    output logic [15:0] fetch_count
);

    typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

    state_t      state;
    logic [15:0] fetch_pc;
    // Word that arrived while IF/ID was stalled; it waits here so the
    // memory is not asked for it twice.
    logic [15:0] hold_pc;
    logic [15:0] hold_instr;

    // Request is gated by reset so memory sees no request while reset is
    // asserted, and rises as soon as reset deasserts in S_FETCH.
    assign imem_req  = reset && (state == S_FETCH);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_FETCH;
            fetch_pc        <= RESET_PC;
            hold_pc         <= RESET_PC;
            hold_instr      <= NOP_INSTR;
            pc_out          <= RESET_PC;
            pc_plus2_out    <= RESET_PC + 16'd2;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
            fetch_count     <= 16'd0;
        end else if (branch_taken) begin
            // Redirect beats stall, ready and state: any response this cycle
            // belongs to the wrong path and is dropped, and the flush bubble
            // is forced into IF/ID even under stall.
            state           <= S_FETCH;
            fetch_pc        <= {branch_target[15:1], 1'b0};
            hold_pc         <= RESET_PC;
            hold_instr      <= NOP_INSTR;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        if (!stall) begin
                            pc_out          <= fetch_pc;
                            pc_plus2_out    <= fetch_pc + 16'd2;
                            instruction_out <= imem_rdata;
                            valid_out       <= 1'b1;
                            fetch_pc        <= fetch_pc + 16'd2;
                            fetch_count     <= fetch_count + 16'd1;
                        end else begin
                            hold_pc    <= fetch_pc;
                            hold_instr <= imem_rdata;
                            state      <= S_HOLD;
                        end
                    end else if (!stall) begin
                        // Memory still busy: push a bubble, keep PCs.
                        instruction_out <= NOP_INSTR;
                        valid_out       <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // imem_req is low here, so any imem_ready is ignored.
                    if (!stall) begin
                        pc_out          <= hold_pc;
                        pc_plus2_out    <= hold_pc + 16'd2;
                        instruction_out <= hold_instr;
                        valid_out       <= 1'b1;
                        fetch_pc        <= fetch_pc + 16'd2;
                        fetch_count     <= fetch_count + 16'd1;
                        state           <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. Inputs change 1 time unit after the
//   rising edge; outputs are checked at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2_out;
    logic [15:0] instruction_out;
    logic        valid_out;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    if_fetch_stage #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .pc_out          (pc_out),
        .pc_plus2_out    (pc_plus2_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] pc, input logic [15:0] pc2,
                           input logic [15:0] ins, input logic vld, input logic [15:0] cnt);
        chk({tag, ".pc"},    pc_out,          pc);
        chk({tag, ".pc2"},   pc_plus2_out,    pc2);
        chk({tag, ".instr"}, instruction_out, ins);
        chk({tag, ".valid"}, {15'd0, valid_out}, {15'd0, vld});
        chk({tag, ".count"}, fetch_count,     cnt);
    endtask

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_rdata    = 16'h0000;
        imem_ready    = 1'b0;

        // Reset state
        step();
        step();
        chk_out("rst", 16'h0000, 16'h0002, 16'h0000, 1'b0, 16'd0);
        chk("rst.req", {15'd0, imem_req}, 16'd0);
        reset = 1'b1;
        #1;
        chk("rel.req",  {15'd0, imem_req}, 16'd1);
        chk("rel.addr", imem_addr, 16'h0000);

        // 1: single-cycle memory, three back-to-back words
        imem_ready = 1'b1; imem_rdata = 16'h1234;
        step();
        chk_out("t1a", 16'h0000, 16'h0002, 16'h1234, 1'b1, 16'd1);
        chk("t1a.addr", imem_addr, 16'h0002);
        imem_rdata = 16'h5678;
        step();
        chk_out("t1b", 16'h0002, 16'h0004, 16'h5678, 1'b1, 16'd2);
        imem_rdata = 16'h9ABC;
        step();
        chk_out("t1c", 16'h0004, 16'h0006, 16'h9ABC, 1'b1, 16'd3);
        chk("t1c.addr", imem_addr, 16'h0006);

        // 2: three-cycle latency -> two bubbles, PC held
        imem_ready = 1'b0; imem_rdata = 16'hEEEE;
        step();
        chk_out("t2b0", 16'h0004, 16'h0006, 16'h0000, 1'b0, 16'd3);
        chk("t2b0.addr", imem_addr, 16'h0006);
        step();
        chk_out("t2b1", 16'h0004, 16'h0006, 16'h0000, 1'b0, 16'd3);
        imem_ready = 1'b1; imem_rdata = 16'h1111;
        step();
        chk_out("t2w", 16'h0006, 16'h0008, 16'h1111, 1'b1, 16'd4);
        chk("t2w.addr", imem_addr, 16'h0008);

        // 3: stall lands with a response at 0x0008, held 4 cycles
        imem_ready = 1'b1; imem_rdata = 16'hABCD; stall = 1'b1;
        step();
        chk_out("t3s0", 16'h0006, 16'h0008, 16'h1111, 1'b1, 16'd4);
        chk("t3s0.req", {15'd0, imem_req}, 16'd0);
        // stray ready while imem_req=0 must be ignored
        imem_rdata = 16'hFFFF;
        step();
        step();
        step();
        chk_out("t3s3", 16'h0006, 16'h0008, 16'h1111, 1'b1, 16'd4);
        chk("t3s3.req", {15'd0, imem_req}, 16'd0);
        stall = 1'b0; imem_ready = 1'b0;
        step();
        chk_out("t3rel", 16'h0008, 16'h000A, 16'hABCD, 1'b1, 16'd5);
        chk("t3rel.req",  {15'd0, imem_req}, 16'd1);
        chk("t3rel.addr", imem_addr, 16'h000A);
        imem_ready = 1'b1; imem_rdata = 16'h3333;
        step();
        chk_out("t3nxt", 16'h000A, 16'h000C, 16'h3333, 1'b1, 16'd6);

        // 4: redirect with ready and stall in the same cycle
        branch_taken = 1'b1; branch_target = 16'h0041;
        imem_ready = 1'b1; imem_rdata = 16'hDEAD; stall = 1'b1;
        step();
        chk("t4.valid", {15'd0, valid_out}, 16'd0);
        chk("t4.instr", instruction_out, 16'h0000);
        chk("t4.addr",  imem_addr, 16'h0040);
        chk("t4.count", fetch_count, 16'd6);
        chk("t4.req",   {15'd0, imem_req}, 16'd1);
        branch_taken = 1'b0; stall = 1'b0; imem_rdata = 16'h4444;
        step();
        chk_out("t4tgt", 16'h0040, 16'h0042, 16'h4444, 1'b1, 16'd7);

        // 5: redirect to 0xFFFE, wrap of PC arithmetic
        branch_taken = 1'b1; branch_target = 16'hFFFE; imem_rdata = 16'h5555;
        step();
        chk("t5.valid", {15'd0, valid_out}, 16'd0);
        chk("t5.addr",  imem_addr, 16'hFFFE);
        chk("t5.count", fetch_count, 16'd7);
        branch_taken = 1'b0; imem_rdata = 16'h6666;
        step();
        chk_out("t5a", 16'hFFFE, 16'h0000, 16'h6666, 1'b1, 16'd8);
        chk("t5a.addr", imem_addr, 16'h0000);
        imem_rdata = 16'h7777;
        step();
        chk_out("t5b", 16'h0000, 16'h0002, 16'h7777, 1'b1, 16'd9);

        // 6: async reset while in S_HOLD
        stall = 1'b1; imem_rdata = 16'h8888;
        step();
        chk("t6.hold.req", {15'd0, imem_req}, 16'd0);
        #2;
        reset = 1'b0;
        #1;
        // still mid-cycle: reset values must already be visible
        chk_out("t6rst", 16'h0000, 16'h0002, 16'h0000, 1'b0, 16'd0);
        chk("t6rst.req", {15'd0, imem_req}, 16'd0);
        step();
        stall = 1'b0; imem_rdata = 16'h9999; imem_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("t6rel.req",  {15'd0, imem_req}, 16'd1);
        chk("t6rel.addr", imem_addr, 16'h0000);
        step();
        chk_out("t6f", 16'h0000, 16'h0002, 16'h9999, 1'b1, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
